// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

  // Receive controller states.
  typedef enum logic [1:0] {
    IDLE,
    START_CHK,
    RECEIVE,
    CHECK
  } state_t;

  localparam int DATA_W             = 8;
  localparam int FRAME_BITS         = 9;   // 8 data bits + stop bit
  localparam int DEFAULT_BIT_PERIOD = 10;
  localparam int STROBE_CNT_W       = 4;   // counts up to FRAME_BITS strobes
  localparam int CNT_W              = 10;  // holds BIT_PERIOD-1 for BIT_PERIOD up to 1023

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the UART receiver: a cycle counter that wraps at a
// programmable rollover value, plus a strobe counter that spots the last
// bit of a frame. half_done marks the middle of the start bit.
module rx_bit_timer
  import uart_rx_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] rollover,
  output logic             shift_strobe,
  output logic             half_done,
  output logic             frame_done
);

  logic [CNT_W-1:0]        cycle_cnt;
  logic [STROBE_CNT_W-1:0] strobe_cnt;
  logic [CNT_W-1:0]        half_point;

  // Rollover is BIT_PERIOD-1, so this is floor(BIT_PERIOD/2)-1 counted from 0.
  assign half_point   = ((rollover + CNT_W'(1)) >> 1) - CNT_W'(1);
  assign shift_strobe = enable && (cycle_cnt == rollover);
  assign half_done    = enable && (cycle_cnt == half_point);
  assign frame_done   = shift_strobe && (strobe_cnt == STROBE_CNT_W'(FRAME_BITS - 1));

  // Cycle counter: cleared on request, wraps after each full bit period.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values; each control/status flop has a defined reset value.
    if (!n_rst) begin
      cycle_cnt <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
    end else if (enable) begin
      cycle_cnt <= shift_strobe ? '0 : cycle_cnt + CNT_W'(1);
    end
  end

  // Strobe counter: counts shift pulses in a frame, restarts after the last.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strobe_cnt <= '0;
    end else if (clear) begin
      strobe_cnt <= '0;
    end else if (shift_strobe) begin
      strobe_cnt <= frame_done ? '0 : strobe_cnt + STROBE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control and output buffer. Detects the start bit, times the
// nine shift strobes into the external 9-bit shift register, checks the
// stop bit and holds the received byte with ready/overrun/framing flags.
// Optional macro UART_RX_SYNC_EN: adds a 2-flop synchronizer on serial_in
// (all timing then shifts by two cycles relative to the raw line).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD  // legal range 4..1023
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              serial_in,
  input  logic [DATA_W-1:0] packet_data,
  input  logic              stop_bit,
  input  logic              data_read,
  output logic              shift_strobe,
  output logic [DATA_W-1:0] rx_data,
  output logic              data_ready,
  output logic              overrun_error,
  output logic              framing_error,
  output logic              rx_busy
);

  state_t state, state_next;
  logic   line;
  logic   prev_in;
  logic   start_edge;
  logic   timer_en;
  logic   timer_clear;
  logic   half_done;
  logic   frame_done;
  logic   load;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end

  assign line = sync_q[1];
`else
  assign line = serial_in;
`endif

  // Previous line level for falling-edge detection; idle level is high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_in <= 1'b1;
    end else begin
      prev_in <= line;
    end
  end

  assign start_edge = prev_in & ~line;

  rx_bit_timer u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (timer_en),
    .clear        (timer_clear),
    .rollover     (CNT_W'(BIT_PERIOD - 1)),
    .shift_strobe (shift_strobe),
    .half_done    (half_done),
    .frame_done   (frame_done)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and timer control.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_next  = state;
    timer_clear = 1'b0;
    timer_en    = (state == START_CHK) || (state == RECEIVE);
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next  = START_CHK;
          timer_clear = 1'b1;
        end
      end
      START_CHK: begin
        if (half_done) begin
          if (line) begin
            state_next = IDLE;      // line back high mid start bit: false start
          end else begin
            state_next  = RECEIVE;
            timer_clear = 1'b1;
          end
        end
      end
      RECEIVE: begin
        if (frame_done) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign load    = (state == CHECK) && stop_bit;
  assign rx_busy = (state != IDLE);

  // Holding register and host-visible status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (load) begin
        // A read in the same cycle as a load consumes the old byte: no overrun.
        rx_data    <= packet_data;
        data_ready <= 1'b1;
        if (data_read) begin
          overrun_error <= 1'b0;
        end else if (data_ready) begin
          overrun_error <= 1'b1;
        end
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      if ((state == CHECK) && !stop_bit) begin
        framing_error <= 1'b1;
      end else if ((state == IDLE) && start_edge) begin
        framing_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural 9-bit shift register.
module tb_uart_rx_ctrl;

  localparam int BP   = 10;
  localparam int HALF = BP / 2;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic [7:0] packet_data;
  logic       stop_bit;
  logic       data_read;
  logic       shift_strobe;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       rx_busy;

  logic [8:0] sr;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         strobe_q[$];
  int         dr_rise = -1;
  logic       dr_q = 1'b0;
  logic       fe_after_start;
  int         e_cyc;

  uart_rx_ctrl #(.BIT_PERIOD(BP)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .packet_data   (packet_data),
    .stop_bit      (stop_bit),
    .data_read     (data_read),
    .shift_strobe  (shift_strobe),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receive shift register model: LSB-first, stop bit ends up in bit 8.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr <= '0;
    else if (shift_strobe) sr <= {serial_in, sr[8:1]};
  end
  assign packet_data = sr[7:0];
  assign stop_bit    = sr[8];

  // Monitor: strobe cycles and the cycle data_ready first becomes visible.
  always @(negedge clk) begin
    if (shift_strobe) strobe_q.push_back(cyc);
    if (data_ready && !dr_q) dr_rise = cyc;
    dr_q = data_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one frame starting at the current negedge (cycle E). Optionally
  // pulse data_read in the CHECK cycle (E+HALF+9*BP+1). Ends at E+10*BP+1.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_chk);
    strobe_q.delete();
    dr_rise   = -1;
    e_cyc     = cyc;
    serial_in = 1'b0;
    @(negedge clk);
    fe_after_start = framing_error;
    repeat (BP - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (BP) @(negedge clk);
    end
    serial_in = stop;
    for (int j = 0; j < BP; j++) begin
      data_read = rd_chk && (j == HALF + 1);
      @(negedge clk);
    end
    data_read = 1'b0;
    serial_in = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pre_read;
    logic       rd_chk;
    logic [7:0] exp_rx;
    logic       exp_rdy;
    logic       exp_ovr;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int busy_cnt;
    int last_busy;
    int e;

    vecs[0] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1}; // framing error, rx held
    vecs[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0}; // overrun
    vecs[3] = '{8'h44, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0}; // read clears both first
    vecs[4] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0}; // read in CHECK: load wins
    vecs[5] = '{8'h99, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1}; // framing, ready kept
    vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0}; // overrun, fe cleared

    serial_in = 1'b1;
    data_read = 1'b0;
    n_rst     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset data_ready", data_ready, 1'b0);
    check("reset overrun", overrun_error, 1'b0);
    check("reset framing", framing_error, 1'b0);
    check("reset rx_busy", rx_busy, 1'b0);
    check("reset shift_strobe", shift_strobe, 1'b0);
    n_rst = 1'b1;

    // Frame 0xA5 with the line falling in cycle 20.
    while (cyc < 20) @(negedge clk);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t1 strobe count", strobe_q.size(), 9);
    for (int k = 1; k <= 9; k++) begin
      if (k <= strobe_q.size()) check($sformatf("t1 strobe %0d cycle", k), strobe_q[k-1], 20 + HALF + k * BP);
    end
    check("t1 data_ready cycle", dr_rise, 117);
    check("t1 rx_data", rx_data, 8'hA5);
    check("t1 data_ready", data_ready, 1'b1);
    check("t1 framing", framing_error, 1'b0);
    check("t1 overrun", overrun_error, 1'b0);

    // Glitch: low for 3 cycles then high -> false start.
    strobe_q.delete();
    e         = cyc;
    busy_cnt  = 0;
    last_busy = -1;
    serial_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) serial_in = 1'b1;
      @(negedge clk);
      if (rx_busy) begin
        busy_cnt++;
        last_busy = cyc;
      end
    end
    check("glitch busy cycles", busy_cnt, 5);
    check("glitch last busy", last_busy, e + HALF);
    check("glitch strobes", strobe_q.size(), 0);
    check("glitch rx_data", rx_data, 8'hA5);
    check("glitch data_ready", data_ready, 1'b1);

    // Table of back-to-back frames.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre_read) begin
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        check($sformatf("v%0d read data_ready", v), data_ready, 1'b0);
        check($sformatf("v%0d read overrun", v), overrun_error, 1'b0);
      end
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].rd_chk);
      check($sformatf("v%0d fe after start", v), fe_after_start, 1'b0);
      check($sformatf("v%0d strobes", v), strobe_q.size(), 9);
      check($sformatf("v%0d rx_data", v), rx_data, vecs[v].exp_rx);
      check($sformatf("v%0d data_ready", v), data_ready, vecs[v].exp_rdy);
      check($sformatf("v%0d overrun", v), overrun_error, vecs[v].exp_ovr);
      check($sformatf("v%0d framing", v), framing_error, vecs[v].exp_fe);
    end

    // Reset after the 4th strobe of a frame.
    strobe_q.delete();
    serial_in = 1'b0;
    repeat (BP) @(negedge clk);
    serial_in = 1'b1;
    repeat (4 * BP) @(negedge clk);
    check("rst strobes before reset", strobe_q.size(), 4);
    n_rst = 1'b0;
    #1;
    check("rst rx_data", rx_data, 8'h00);
    check("rst data_ready", data_ready, 1'b0);
    check("rst overrun", overrun_error, 1'b0);
    check("rst framing", framing_error, 1'b0);
    check("rst rx_busy", rx_busy, 1'b0);
    check("rst shift_strobe", shift_strobe, 1'b0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    check("post-rst strobes", strobe_q.size(), 9);
    check("post-rst rx_data", rx_data, 8'h81);
    check("post-rst data_ready", data_ready, 1'b1);
    check("post-rst overrun", overrun_error, 1'b0);
    check("post-rst framing", framing_error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side control and output buffer for the UART receiver, one stage downstream of the 9-bit receive shift register.
- Detects the start bit and times each bit period.
- Drives shift_strobe into the shift register.
- After 9 strobes, checks the captured stop bit, loads the 8-bit payload into a holding register, and flags data_ready, overrun_error and framing_error to the host.

Parameters:
BIT_PERIOD, 10, clock cycles per UART bit; legal range 4..1023; HALF = BIT_PERIOD/2 (integer floor).

Ports:
clk  input  1  system clock.
n_rst  input  1  asynchronous active-low reset.
serial_in  input  1  UART line; idle high.
packet_data  input  8  payload from the 9-bit shift register.
stop_bit  input  1  stop bit from the 9-bit shift register.
data_read  input  1  host pulse; acknowledges rx_data.
shift_strobe  output  1  one-cycle shift pulse to the shift register.
rx_data  output  8  held received byte.
data_ready  output  1  rx_data valid and unread.
overrun_error  output  1  unread byte overwritten.
framing_error  output  1  last frame had stop_bit==0.
rx_busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Clock and reset: single clock clk; reset n_rst is asynchronous, active-low.
- Reset values: state=IDLE, shift_strobe=0, rx_data=8'h00, data_ready=0, overrun_error=0, framing_error=0, rx_busy=0. The internal prev_in register resets to 1.
- Start detect: start_edge = prev_in & ~serial_in (prev_in is serial_in registered). Call the cycle in which start_edge is true E.
- IDLE: on start_edge, go to START_CHK, clear the cycle counter, and clear framing_error.
- START_CHK: count cycles. In cycle E+HALF, sample serial_in:
  - 1: false start, return to IDLE with no strobe.
  - 0: go to RECEIVE and clear the counter.
- RECEIVE: the counter runs 0..BIT_PERIOD-1 and wraps.
  - shift_strobe=1 in the cycle the counter equals BIT_PERIOD-1, so strobes fall in cycles E+HALF+k*BIT_PERIOD, k=1..9.
  - A 4-bit strobe counter counts the strobes. After the 9th strobe (cycle S9), go to CHECK.
- CHECK, one cycle at S9+1; stop_bit and packet_data are already updated.
  - stop_bit==1: rx_data<=packet_data and data_ready<=1. If data_ready was already 1 and data_read is 0 this cycle, overrun_error<=1.
  - stop_bit==0: framing_error<=1; rx_data and data_ready are unchanged.
  - Next state is IDLE. Outputs are visible from S9+2.
- data_read (any state): clears data_ready and overrun_error next cycle.
  - If data_read coincides with a CHECK load, the load wins: data_ready=1 and no overrun.
- Only the start-check sample and the shift register sample serial_in. Line glitches between samples are ignored.
- A start_edge during CHECK is not accepted. The line must be seen high in IDLE before a new start is detected, which the stop bit guarantees.
- Reset mid-frame: immediate return to reset values. No partial byte is loaded.
- rx_busy = (state != IDLE), decoded from registered state.

Optional Feature:
UART_RX_SYNC_EN
- Defined: serial_in passes through a 2-flop synchronizer (reset value 1) before edge detect and sampling. All timing above shifts by +2 cycles relative to the raw line.
- Undefined: serial_in is used directly and must already be synchronous to clk.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum {IDLE, START_CHK, RECEIVE, CHECK};
  - DATA_W=8;
  - FRAME_BITS=9;
  - DEFAULT_BIT_PERIOD=10;
  - the strobe counter width.
- One sub-module, rx_bit_timer: the cycle counter plus strobe counter, with inputs enable, clear and rollover value. It outputs shift_strobe, half_done and frame_done.
- The FSM and output buffer stay in uart_rx_ctrl.

Test Plan:
1. BIT_PERIOD=10, line falls at E=20, frame 0xA5 LSB-first, stop=1 -> strobes at cycles 35,45,...,115; rx_data=0xA5 and data_ready=1 from cycle 117; framing_error=0.
2. Line low for 3 cycles then high (glitch) -> return to IDLE at E+5; no shift_strobe; rx_busy high for 5 cycles only.
3. Frame 0x3C with stop bit 0 -> framing_error=1, data_ready stays 0, rx_data holds its prior value; framing_error clears on the next start edge.
4. Two frames 0x11 then 0x22 with no data_read -> rx_data=0x22, data_ready=1, overrun_error=1; one data_read pulse -> both flags 0 next cycle.
5. data_read asserted in the CHECK cycle of frame 0x55 while data_ready=1 -> rx_data=0x55, data_ready=1, overrun_error=0.
6. n_rst pulsed after the 4th strobe of a frame -> all outputs at reset values; the following clean frame 0x81 is received correctly.
